// File: rtl/tx_egress_queue.sv
// Egress descriptor queue for one TX port: two priority FIFOs feed a single output register
// toward tx_mac_control, using strict priority with a starvation guard for the low class.
module tx_egress_queue #(
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         switch_clk,
    input  logic                         switch_rst_n,
    input  logic                         enq_valid_i,
    input  logic                         enq_prio_i,
    input  logic [ADDR_W-1:0]            enq_ptr_i,
    output logic                         enq_ready_o,
    input  logic                         flush_i,
    output logic                         voq_valid_o,
    output logic [ADDR_W-1:0]            voq_ptr_o,
    input  logic                         voq_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   hi_count_o,
    output logic [$clog2(DEPTH+1)-1:0]   lo_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT+1) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

    // Handshakes: enqueue fires on enq_valid_i && enq_ready_o, transfer fires on
    // voq_valid_o && voq_ready_i; in both cases the data is held stable until it fires.
    typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   mem [2][DEPTH];
    logic [PW-1:0]       wr_ptr [2];
    logic [PW-1:0]       rd_ptr [2];
    logic [CW-1:0]       count [2];
    logic [SW-1:0]       starve_cnt;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic [1:0]          push_v, pop_v;
    logic                hi_ne, lo_ne, grant_hi, do_pop, enq_fire, clear;

    // Flush and reset share one clear path so no partial state survives either.
    assign clear       = !switch_rst_n || flush_i;
    assign hi_ne       = (count[1] != '0);
    assign lo_ne       = (count[0] != '0);
    assign enq_ready_o = (count[enq_prio_i] != FULL_CNT) && !flush_i;
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign grant_hi    = hi_ne && (!lo_ne || (STARVE_LIMIT == 0) || (starve_cnt < LIMIT));
    assign push_v      = enq_fire ? (enq_prio_i ? 2'b10 : 2'b01) : 2'b00;
    assign pop_v       = do_pop ? (grant_hi ? 2'b10 : 2'b01) : 2'b00;
    assign voq_valid_o = (state == LOADED);
    assign hi_count_o  = count[1];
    assign lo_count_o  = count[0];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = voq_ptr_o;
        do_pop    = 1'b0;
        if ((state == EMPTY) || voq_ready_i) begin
            if (hi_ne || lo_ne) begin
                do_pop    = 1'b1;
                state_nxt = LOADED;
                ptr_nxt   = mem[grant_hi][rd_ptr[grant_hi]];
            end else begin
                state_nxt = EMPTY;
            end
        end
    end

    always_ff @(posedge switch_clk) begin
        if (clear) begin
            state      <= EMPTY;
            voq_ptr_o  <= '0;
            starve_cnt <= '0;
        end else begin
            state     <= state_nxt;
            voq_ptr_o <= ptr_nxt;
            if (!lo_ne) begin
                starve_cnt <= '0;
            end else if (do_pop) begin
                if (grant_hi) begin
                    if (starve_cnt != '1) starve_cnt <= starve_cnt + SW'(1);
                end else begin
                    starve_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge switch_clk) begin
        for (int c = 0; c < 2; c++) begin
            if (clear) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end else begin
                if (push_v[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
                if (pop_v[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
                count[c] <= count[c] + CW'(push_v[c]) - CW'(pop_v[c]);
            end
        end
    end

    // Storage needs no reset; pointers and counts define which entries are live.
    always_ff @(posedge switch_clk) begin
        if (enq_fire) mem[enq_prio_i][wr_ptr[enq_prio_i]] <= enq_ptr_i;
    end

endmodule

// File: tb/tb_tx_egress_queue.sv
// Bench for tx_egress_queue: table-driven vectors for basic latency/priority,
// plus directed sequences for full, starvation, flush, pointer wrap and mid-stream reset.
module tb_tx_egress_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_prio = 1'b0;
    logic [15:0] enq_ptr = '0;
    logic        enq_ready;
    logic        flush = 1'b0;
    logic        voq_valid;
    logic [15:0] voq_ptr;
    logic        voq_ready = 1'b0;
    logic [4:0]  hi_count, lo_count;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic mon_en = 1'b0;
    logic [15:0] exp_q[$];

    tx_egress_queue #(.ADDR_W(16), .DEPTH(16), .STARVE_LIMIT(4)) dut (
        .switch_clk   (clk),
        .switch_rst_n (rst_n),
        .enq_valid_i  (enq_valid),
        .enq_prio_i   (enq_prio),
        .enq_ptr_i    (enq_ptr),
        .enq_ready_o  (enq_ready),
        .flush_i      (flush),
        .voq_valid_o  (voq_valid),
        .voq_ptr_o    (voq_ptr),
        .voq_ready_i  (voq_ready),
        .hi_count_o   (hi_count),
        .lo_count_o   (lo_count)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: a transfer happens at the next posedge whenever valid && ready at negedge
    always @(negedge clk) begin
        if (mon_en && voq_valid && voq_ready) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL xfer_unexpected: got %h, required no transfer", voq_ptr);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (voq_ptr !== e) begin
                    err_cnt++;
                    $display("FAIL xfer_order: got %h, required %h", voq_ptr, e);
                end
            end
        end
    end

    typedef struct {
        logic        rst_n;
        logic        enq_valid;
        logic        enq_prio;
        logic [15:0] enq_ptr;
        logic        flush;
        logic        voq_ready;
        logic        chk_rdy;
        logic        exp_rdy;
        logic        exp_valid;
        logic        chk_ptr;
        logic [15:0] exp_ptr;
        logic [4:0]  exp_hi;
        logic [4:0]  exp_lo;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        vec_cnt++;
        if (got !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %h, required %h", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic prio, input logic [15:0] ptr);
        enq_valid = 1'b1;
        enq_prio  = prio;
        enq_ptr   = ptr;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        voq_ready = 1'b0;
        enq_valid = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, voq_valid, 0);
        chk({name, "_hi"}, hi_count, 0);
        chk({name, "_lo"}, lo_count, 0);
        chk({name, "_ptr"}, voq_ptr, 0);
        enq_prio = 1'b0;
        #1;
        chk({name, "_rdy_lo"}, enq_ready, 1);
        enq_prio = 1'b1;
        #1;
        chk({name, "_rdy_hi"}, enq_ready, 1);
        enq_prio = 1'b0;
    endtask

    initial begin
        logic acc;
        int   tries;

        // rst, ev, ep, ptr, flush, rdy, chk_rdy, exp_rdy, exp_valid, chk_ptr, exp_ptr, hi, lo
        vecs[0]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0};
        vecs[1]  = '{1, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h0000, 0, 0};
        vecs[2]  = '{1, 1, 0, 16'h1000, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 1};
        vecs[3]  = '{1, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 1, 16'h1000, 0, 0};
        vecs[4]  = '{1, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 0, 16'h0000, 0, 0};
        vecs[5]  = '{1, 1, 0, 16'h2000, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 1};
        vecs[6]  = '{1, 1, 0, 16'h2100, 0, 0, 1, 1, 1, 1, 16'h2000, 0, 1};
        vecs[7]  = '{1, 1, 1, 16'h3000, 0, 0, 1, 1, 1, 1, 16'h2000, 1, 1};
        vecs[8]  = '{1, 0, 0, 16'h0000, 0, 1, 1, 1, 1, 1, 16'h3000, 0, 1};
        vecs[9]  = '{1, 0, 0, 16'h0000, 0, 1, 1, 1, 1, 1, 16'h2100, 0, 0};
        vecs[10] = '{1, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 0, 16'h0000, 0, 0};

        // Reset, single-descriptor latency, priority ordering with back-to-back transfers
        for (int i = 0; i < NV; i++) begin
            rst_n     = vecs[i].rst_n;
            enq_valid = vecs[i].enq_valid;
            enq_prio  = vecs[i].enq_prio;
            enq_ptr   = vecs[i].enq_ptr;
            flush     = vecs[i].flush;
            voq_ready = vecs[i].voq_ready;
            #1;
            if (vecs[i].chk_rdy) chk($sformatf("v%0d_enq_ready", i), enq_ready, vecs[i].exp_rdy);
            tick();
            chk($sformatf("v%0d_valid", i), voq_valid, vecs[i].exp_valid);
            if (vecs[i].chk_ptr) chk($sformatf("v%0d_ptr", i), voq_ptr, vecs[i].exp_ptr);
            chk($sformatf("v%0d_hi", i), hi_count, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo_count, vecs[i].exp_lo);
        end
        enq_valid = 1'b0;
        voq_ready = 1'b0;

        // Fill high class: output register plus DEPTH entries
        do_reset();
        for (int i = 0; i < 17; i++) begin
            enq_valid = 1'b1;
            enq_prio  = 1'b1;
            enq_ptr   = 16'h4000 + 16'(i);
            #1;
            chk("fill_rdy", enq_ready, 1);
            tick();
        end
        enq_valid = 1'b0;
        chk("full_hi_count", hi_count, 16);
        chk("full_valid", voq_valid, 1);
        chk("full_ptr", voq_ptr, 16'h4000);
        #1;
        chk("full_rdy_hi", enq_ready, 0);
        enq_prio = 1'b0;
        #1;
        chk("full_rdy_lo", enq_ready, 1);
        enq_valid = 1'b1;
        enq_prio  = 1'b1;
        enq_ptr   = 16'h4EEE;
        #1;
        chk("full_offer_rdy", enq_ready, 0);
        tick();
        chk("full_offer_hi", hi_count, 16);
        chk("full_offer_ptr", voq_ptr, 16'h4000);
        voq_ready = 1'b1;
        tick();
        chk("full_pop_nopass_hi", hi_count, 15);
        chk("full_pop_nopass_ptr", voq_ptr, 16'h4001);
        enq_ptr = 16'h4011;
        #1;
        chk("popenq_rdy", enq_ready, 1);
        tick();
        enq_valid = 1'b0;
        chk("popenq_hi", hi_count, 15);
        chk("popenq_ptr", voq_ptr, 16'h4002);
        chk("popenq_valid", voq_valid, 1);
        for (int i = 2; i < 18; i++) exp_q.push_back(16'h4000 + 16'(i));
        mon_en = 1'b1;
        wait_drain("full_drain", 40);
        chk("full_drain_valid", voq_valid, 0);
        chk("full_drain_hi", hi_count, 0);

        // Starvation guard: a low dummy occupies the output register while 8 hi + 2 lo queue
        do_reset();
        mon_en = 1'b1;
        enq(1'b0, 16'hD000);
        for (int i = 0; i < 8; i++) enq(1'b1, 16'h5000 + 16'(i));
        enq(1'b0, 16'h6000);
        enq(1'b0, 16'h6001);
        chk("starve_hi", hi_count, 8);
        chk("starve_lo", lo_count, 2);
        exp_q.push_back(16'hD000);
        exp_q.push_back(16'h5000); exp_q.push_back(16'h5001);
        exp_q.push_back(16'h5002); exp_q.push_back(16'h5003);
        exp_q.push_back(16'h6000);
        exp_q.push_back(16'h5004); exp_q.push_back(16'h5005);
        exp_q.push_back(16'h5006); exp_q.push_back(16'h5007);
        exp_q.push_back(16'h6001);
        voq_ready = 1'b1;
        wait_drain("starve_drain", 40);
        chk("starve_end_valid", voq_valid, 0);

        // Flush with queued descriptors and a concurrent offer
        do_reset();
        mon_en = 1'b1;
        enq(1'b0, 16'h7000);
        enq(1'b0, 16'h7001);
        enq(1'b0, 16'h7002);
        enq(1'b1, 16'h7003);
        enq(1'b0, 16'h7004);
        chk("preflush_lo", lo_count, 3);
        chk("preflush_hi", hi_count, 1);
        chk("preflush_ptr", voq_ptr, 16'h7000);
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_prio  = 1'b1;
        enq_ptr   = 16'h7EEE;
        #1;
        chk("flush_enq_rdy", enq_ready, 0);
        tick();
        flush     = 1'b0;
        enq_valid = 1'b0;
        chk_idle("flush");
        voq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postflush_valid", voq_valid, 0);
        end
        exp_q.push_back(16'h7100);
        enq(1'b0, 16'h7100);
        wait_drain("postflush_drain", 10);

        // Pointer wrap: 40 low descriptors with random ready
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            enq_valid = 1'b1;
            enq_prio  = 1'b0;
            enq_ptr   = 16'(i);
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 50) begin
                voq_ready = 1'($urandom_range(0, 1));
                #1;
                acc = enq_ready;
                tick();
                tries++;
            end
            if (acc) exp_q.push_back(16'(i));
            else chk("wrap_enq_timeout", 0, 1);
        end
        enq_valid = 1'b0;
        voq_ready = 1'b1;
        wait_drain("wrap_drain", 100);
        chk("wrap_end_valid", voq_valid, 0);
        chk("wrap_end_lo", lo_count, 0);

        // Reset mid-stream
        voq_ready = 1'b0;
        mon_en = 1'b0;
        for (int i = 0; i < 5; i++) enq(1'b0, 16'h8000 + 16'(i));
        enq(1'b1, 16'h8100);
        do_reset();
        chk_idle("midrst");
        enq(1'b0, 16'h1000);
        chk("midrst_lat_n", voq_valid, 0);
        tick();
        chk("midrst_lat_n1", voq_valid, 1);
        chk("midrst_lat_ptr", voq_ptr, 16'h1000);
        voq_ready = 1'b1;
        tick();
        chk("midrst_xfer_valid", voq_valid, 0);
        chk("midrst_xfer_lo", lo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
